// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: M field register, data-memory request/response FSM and M->W handshake.
// Optional build macro M_ADDR_CHECK_EN traps misaligned half/word accesses into ExcAdM.
module mem_stage_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              respon,
  input  logic              E_to_M_valid,
  output logic              M_allowin,
  input  logic              W_allowin,
  output logic              M_to_W_valid,
  input  logic              MemReadE,
  input  logic              MemWriteE,
  input  logic [1:0]        MemSizeE,
  input  logic [ADDR_W-1:0] ALUoutE,
  input  logic [DATA_W-1:0] WriteDataE,
  input  logic [31:0]       pcE,
  input  logic [4:0]        A3E,
  input  logic              RegWriteE,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [3:0]        data_wstrb,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata,
  output logic [DATA_W-1:0] MemOutM,
  output logic [ADDR_W-1:0] ALUoutM,
  output logic [31:0]       pcM,
  output logic [4:0]        A3M,
  output logic              RegWriteM,
  output logic              ExcAdM
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_CANCEL
  } state_e;

  state_e            state_q,      state_d;
  logic              valid_q,      valid_d;
  logic              mem_read_q,   mem_read_d;
  logic              mem_write_q,  mem_write_d;
  logic [1:0]        mem_size_q,   mem_size_d;
  logic [ADDR_W-1:0] alu_out_q,    alu_out_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic [31:0]       pc_q,         pc_d;
  logic [4:0]        a3_q,         a3_d;
  logic              reg_write_q,  reg_write_d;
  logic [DATA_W-1:0] mem_out_q,    mem_out_d;

  logic memop;
  logic ready_go;

  assign memop        = mem_read_q | mem_write_q;
  assign ready_go     = !memop || (state_q == S_DONE);
  // CANCEL still owes the bus one data_ok, so nothing new may enter until it drains.
  assign M_allowin    = (state_q != S_CANCEL) && (!valid_q || (ready_go && W_allowin));
  assign M_to_W_valid = valid_q && ready_go;

`ifdef M_ADDR_CHECK_EN
  logic exc_ad_q, exc_ad_d;
  logic misalign_e;

  assign misalign_e = (MemSizeE == 2'd1 && ALUoutE[0]) ||
                      (MemSizeE == 2'd2 && ALUoutE[1:0] != 2'b00);
  assign ExcAdM     = exc_ad_q;
`else
  assign ExcAdM     = 1'b0;
`endif

  always_comb begin
    // NOTE: every next-state signal takes its hold value first so no path leaves it unassigned (no latches).
    state_d      = state_q;
    valid_d      = valid_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_size_d   = mem_size_q;
    alu_out_d    = alu_out_q;
    write_data_d = write_data_q;
    pc_d         = pc_q;
    a3_d         = a3_q;
    reg_write_d  = reg_write_q;
    mem_out_d    = mem_out_q;
`ifdef M_ADDR_CHECK_EN
    exc_ad_d     = exc_ad_q;
`endif

    unique case (state_q)
      S_REQ:    if (data_addr_ok) state_d = S_WAIT;
      S_WAIT: begin
        if (data_data_ok) begin
          state_d = S_DONE;
          if (mem_read_q) mem_out_d = data_rdata;
        end
      end
      S_CANCEL: if (data_data_ok) state_d = S_IDLE;
      default:  ;
    endcase

    if (respon) begin
      valid_d   = 1'b0;
      mem_out_d = mem_out_q;
      unique case (state_q)
        S_REQ:    state_d = data_addr_ok ? S_CANCEL : S_IDLE;
        S_WAIT:   state_d = data_data_ok ? S_IDLE : S_CANCEL;
        S_CANCEL: ;
        default:  state_d = S_IDLE;
      endcase
    end else if (M_allowin) begin
      valid_d = E_to_M_valid;
      state_d = S_IDLE;
      if (E_to_M_valid) begin
        mem_read_d   = MemReadE;
        mem_write_d  = MemWriteE;
        mem_size_d   = MemSizeE;
        alu_out_d    = ALUoutE;
        write_data_d = WriteDataE;
        pc_d         = pcE;
        a3_d         = A3E;
        reg_write_d  = RegWriteE;
        if (MemReadE || MemWriteE) state_d = S_REQ;
`ifdef M_ADDR_CHECK_EN
        exc_ad_d = (MemReadE || MemWriteE) && misalign_e;
        if (exc_ad_d) state_d = S_DONE;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      valid_q      <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_size_q   <= 2'd0;
      alu_out_q    <= '0;
      write_data_q <= '0;
      pc_q         <= '0;
      a3_q         <= '0;
      reg_write_q  <= 1'b0;
      mem_out_q    <= '0;
`ifdef M_ADDR_CHECK_EN
      exc_ad_q     <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q      <= state_d;
      valid_q      <= valid_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_size_q   <= mem_size_d;
      alu_out_q    <= alu_out_d;
      write_data_q <= write_data_d;
      pc_q         <= pc_d;
      a3_q         <= a3_d;
      reg_write_q  <= reg_write_d;
      mem_out_q    <= mem_out_d;
`ifdef M_ADDR_CHECK_EN
      exc_ad_q     <= exc_ad_d;
`endif
    end
  end

  assign data_req  = (state_q == S_REQ);
  assign data_wr   = mem_write_q;
  assign data_size = mem_size_q;
  assign data_addr = alu_out_q;

  // Sub-word stores replicate the data across lanes; strobes pick the target bytes.
  always_comb begin
    data_wdata = write_data_q;
    data_wstrb = 4'b1111;
    unique case (mem_size_q)
      2'd0: begin
        data_wdata = {4{write_data_q[7:0]}};
        data_wstrb = 4'b0001 << alu_out_q[1:0];
      end
      2'd1: begin
        data_wdata = {2{write_data_q[15:0]}};
        data_wstrb = alu_out_q[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
    if (!mem_write_q) data_wstrb = 4'b0000;
  end

  assign MemOutM   = mem_out_q;
  assign ALUoutM   = alu_out_q;
  assign pcM       = pc_q;
  assign A3M       = a3_q;
  assign RegWriteM = reg_write_q;

endmodule
